// File: rtl/audio_sram_sequencer.sv
// ---------------------------------------------------------------------------
// audio_sram_sequencer
//
// Records 16-bit audio samples into an asynchronous SRAM and plays them back.
// There is one SRAM access per sample_stb. Each access holds WE_N or OE_N low
// for ACC_CYCLES clk cycles. A write is followed by one hold cycle, during
// which DQ is still driven after WE_N has risen.
//
// Parameters
//   ADDR_W      SRAM word-address width
//   ACC_CYCLES  clk cycles WE_N / OE_N is held low per access (1..7)
//
// Build option
//   AUDIO_SEQ_PLAYBACK_LOOP_EN  when defined, playback wraps to word 0 at the
//                               end of the recording and runs until stop.
//                               When undefined, playback clears out_sample
//                               one cycle after the last word and returns to
//                               IDLE.
//
// Ports
//   clk          system clock, rising edge
//   AUD_DACLRCK  asynchronous active-low reset
//   sample_stb   one-cycle frame strobe (already synchronous to clk)
//   start/stop   one-cycle control pulses; stop wins when both are high
//   rec_en       1 = record, 0 = playback, sampled on start
//   in_sample    sample to record
//   out_sample   sample read back, qualified by the out_valid pulse
//   busy         sequencer not idle
//   full         recording filled the whole SRAM
//   overrun      sticky: a strobe arrived mid-access and was dropped
//   SRAM_*       asynchronous SRAM pins (active-low strobes, bidirectional DQ)
// ---------------------------------------------------------------------------
module audio_sram_sequencer #(
    parameter int ADDR_W     = 18,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              AUD_DACLRCK,
    input  logic              sample_stb,
    input  logic              start,
    input  logic              stop,
    input  logic              rec_en,
    input  logic [15:0]       in_sample,
    output logic [15:0]       out_sample,
    output logic              out_valid,
    output logic              busy,
    output logic              full,
    output logic              overrun,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    typedef enum logic [2:0] {
        IDLE,
        REC_WAIT,
        REC_WR,
        REC_HOLD,
        PLAY_WAIT,
        PLAY_RD
    } state_t;

    localparam logic [2:0] ACC_LAST = 3'(ACC_CYCLES - 1);

    state_t            state, state_nx;
    logic [2:0]        acc_cnt;
    logic              stop_pend;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   addr_inc;
    logic [ADDR_W:0]   rec_len;
    logic [15:0]       wdata;
    logic              dq_oe;
    logic              clr_pend;

    // Decoded actions for the current cycle.
    logic access_last;
    logic end_req;
    logic rec_start;
    logic play_start;
    logic wr_latch;
    logic wr_commit;
    logic set_full;
    logic rd_commit;
    logic play_wrap;
    logic play_done;
    logic drop_stb;

    // rec_len needs one bit more than addr, so that a recording that fills
    // the whole SRAM (2^ADDR_W words) still has a non-zero length.
    assign addr_inc    = {1'b0, addr} + (ADDR_W + 1)'(1);
    assign access_last = (acc_cnt == ACC_LAST);
    // A stop is honoured either in the cycle it arrives or, if it arrived
    // mid-access, when that access completes.
    assign end_req     = stop || stop_pend;

    // A strobe can only be taken in a WAIT state. If it arrives while an
    // access is still in progress, the strobe is lost.
    assign drop_stb = sample_stb &&
                      (state == REC_WR || state == REC_HOLD || state == PLAY_RD);

    // -----------------------------------------------------------------------
    // Next-state and action decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_nx   = state;
        rec_start  = 1'b0;
        play_start = 1'b0;
        wr_latch   = 1'b0;
        wr_commit  = 1'b0;
        set_full   = 1'b0;
        rd_commit  = 1'b0;
        play_wrap  = 1'b0;
        play_done  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (rec_en) begin
                        rec_start = 1'b1;
                        state_nx  = REC_WAIT;
                    end else if (rec_len != '0) begin
                        play_start = 1'b1;
                        state_nx   = PLAY_WAIT;
                    end
                end
            end

            REC_WAIT: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (sample_stb) begin
                    wr_latch = 1'b1;
                    state_nx = REC_WR;
                end
            end

            REC_WR: begin
                if (access_last) begin
                    state_nx = REC_HOLD;
                end
            end

            REC_HOLD: begin
                wr_commit = 1'b1;
                if (addr == '1) begin
                    set_full = 1'b1;
                    state_nx = IDLE;
                end else if (end_req) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = REC_WAIT;
                end
            end

            PLAY_WAIT: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (sample_stb) begin
                    state_nx = PLAY_RD;
                end
            end

            PLAY_RD: begin
                if (access_last) begin
                    rd_commit = 1'b1;
                    if (addr_inc == rec_len) begin
`ifdef AUDIO_SEQ_PLAYBACK_LOOP_EN
                        play_wrap = 1'b1;
                        state_nx  = end_req ? IDLE : PLAY_WAIT;
`else
                        play_done = 1'b1;
                        state_nx  = IDLE;
`endif
                    end else begin
                        state_nx = end_req ? IDLE : PLAY_WAIT;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, access timer and SRAM strobes
    // The strobes are registered from the next state. This keeps them
    // glitch-free and aligned exactly with the state they belong to. The
    // asynchronous reset therefore deasserts them at once, even in the
    // middle of a write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
            dq_oe     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the values from before this edge.
            state <= state_nx;

            // The access timer restarts on every entry into an access state.
            if (state_nx == state && (state == REC_WR || state == PLAY_RD)) begin
                acc_cnt <= acc_cnt + 3'd1;
            end else begin
                acc_cnt <= '0;
            end

            if (state_nx == IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop && (state == REC_WR || state == REC_HOLD ||
                                  state == PLAY_RD)) begin
                stop_pend <= 1'b1;
            end

            busy      <= (state_nx != IDLE);
            SRAM_CE_N <= (state_nx == IDLE);
            SRAM_WE_N <= (state_nx != REC_WR);
            SRAM_OE_N <= (state_nx != PLAY_RD);
            dq_oe     <= (state_nx == REC_WR || state_nx == REC_HOLD);
        end
    end

    // -----------------------------------------------------------------------
    // Address, length, sample and flag datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            addr       <= '0;
            rec_len    <= '0;
            wdata      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            full       <= 1'b0;
            overrun    <= 1'b0;
            clr_pend   <= 1'b0;
        end else begin
            out_valid <= rd_commit;
            clr_pend  <= rd_commit && play_done;

            if (rec_start) begin
                addr    <= '0;
                rec_len <= '0;
                full    <= 1'b0;
                overrun <= 1'b0;
            end

            if (play_start) begin
                addr    <= '0;
                overrun <= 1'b0;
            end

            if (drop_stb) begin
                overrun <= 1'b1;
            end

            if (wr_latch) begin
                wdata <= in_sample;
            end

            if (wr_commit) begin
                addr    <= addr_inc[ADDR_W-1:0];
                rec_len <= addr_inc;
            end

            if (set_full) begin
                full <= 1'b1;
            end

            if (rd_commit) begin
                out_sample <= SRAM_DQ;
                addr       <= play_wrap ? '0 : addr_inc[ADDR_W-1:0];
            end

            // At the end of a one-shot playback the last sample is shown for
            // one cycle with out_valid, and then the output is cleared.
            if (clr_pend) begin
                out_sample <= '0;
            end
        end
    end

    assign SRAM_ADDR = addr;
    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;
    assign SRAM_DQ   = dq_oe ? wdata : 16'hzzzz;

endmodule

// File: tb/tb_audio_sram_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_sram_sequencer
//
// Directed bench for audio_sram_sequencer. The bench contains a small SRAM
// model. Playback strobes push their expected word and issue cycle onto a
// scoreboard queue. A monitor then pops the queue on each out_valid pulse and
// checks both the data and the latency.
// ---------------------------------------------------------------------------
module tb_audio_sram_sequencer;

    localparam int ADDR_W = 3;
    localparam int ACC    = 3;
`ifdef AUDIO_SEQ_PLAYBACK_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              AUD_DACLRCK;
    logic              sample_stb;
    logic              start;
    logic              stop;
    logic              rec_en;
    logic [15:0]       in_sample;
    logic [15:0]       out_sample;
    logic              out_valid;
    logic              busy;
    logic              full;
    logic              overrun;
    logic [ADDR_W-1:0] SRAM_ADDR;
    wire  [15:0]       SRAM_DQ;
    logic              SRAM_WE_N;
    logic              SRAM_OE_N;
    logic              SRAM_CE_N;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;

    always #5 clk = ~clk;

    audio_sram_sequencer #(
        .ADDR_W     (ADDR_W),
        .ACC_CYCLES (ACC)
    ) dut (
        .clk         (clk),
        .AUD_DACLRCK (AUD_DACLRCK),
        .sample_stb  (sample_stb),
        .start       (start),
        .stop        (stop),
        .rec_en      (rec_en),
        .in_sample   (in_sample),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .busy        (busy),
        .full        (full),
        .overrun     (overrun),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ     (SRAM_DQ),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_UB_N   (SRAM_UB_N),
        .SRAM_LB_N   (SRAM_LB_N)
    );

    // ---------------- SRAM model and strobe counters ----------------
    logic [15:0] mem [2**ADDR_W];
    assign SRAM_DQ = (!SRAM_OE_N && !SRAM_CE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_WE_N && !SRAM_CE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    end

    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(negedge SRAM_WE_N) wr_cnt++;
    always @(negedge SRAM_OE_N) rd_cnt++;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          t;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin : monitor
        exp_t e;
        if (AUD_DACLRCK === 1'b1 && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", {16'b0, out_sample}, {16'b0, e.data});
                check("stb->out_valid latency", cyc - e.t, ACC + 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [15:0] d);
        in_sample  = d;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic play_strobe(input logic [15:0] d);
        exp_q.push_back('{data: d, t: cyc});
        strobe(d);
    endtask

    task automatic pulse_start(input logic rec);
        start  = 1'b1;
        rec_en = rec;
        tick();
        start  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wr0, rd0, wr1, rd1;
        AUD_DACLRCK = 1'b0;
        sample_stb  = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        rec_en      = 1'b0;
        in_sample   = '0;

        // Reset state
        tick(3);
        check("rst busy", {31'b0, busy}, 0);
        check("rst full", {31'b0, full}, 0);
        check("rst overrun", {31'b0, overrun}, 0);
        check("rst out_valid", {31'b0, out_valid}, 0);
        check("rst out_sample", {16'b0, out_sample}, 0);
        check("rst addr", {29'b0, SRAM_ADDR}, 0);
        check("rst strobes", {27'b0, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N,
                              SRAM_UB_N, SRAM_LB_N}, 32'h1f);
        AUD_DACLRCK = 1'b1;
        tick(2);
        wr0 = wr_cnt;
        rd0 = rd_cnt;

        // start together with stop in IDLE
        start = 1'b1; stop = 1'b1; rec_en = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start+stop busy", {31'b0, busy}, 0);
        tick(3);
        check("start+stop CE_N", {31'b0, SRAM_CE_N}, 1);
        check("start+stop no writes", wr_cnt - wr0, 0);
        check("start+stop no reads", rd_cnt - rd0, 0);

        // Record four samples
        pulse_start(1'b1);
        check("rec busy", {31'b0, busy}, 1);
        check("rec CE/UB/LB", {29'b0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 0);
        for (int i = 0; i < 4; i++) begin
            strobe(16'(16'h1111 * (i + 1)));
            if (i == 0) begin
                check("wr WE_N", {31'b0, SRAM_WE_N}, 0);
                check("wr OE_N", {31'b0, SRAM_OE_N}, 1);
                check("wr DQ", {16'b0, SRAM_DQ}, 32'h1111);
                check("wr addr", {29'b0, SRAM_ADDR}, 0);
            end
            tick(ACC);
            if (i == 0) begin
                check("hold WE_N", {31'b0, SRAM_WE_N}, 1);
                check("hold DQ", {16'b0, SRAM_DQ}, 32'h1111);
            end
            tick();
        end
        pulse_stop();
        check("rec stop busy", {31'b0, busy}, 0);
        check("rec stop CE_N", {31'b0, SRAM_CE_N}, 1);
        check("rec write count", wr_cnt - wr0, 4);
        for (int i = 0; i < 4; i++) begin
            check("mem word", {16'b0, mem[i]}, 32'(16'h1111 * (i + 1)));
        end

        // Play back the four samples
        pulse_start(1'b0);
        check("play busy", {31'b0, busy}, 1);
        for (int i = 0; i < 4; i++) begin
            play_strobe(16'(16'h1111 * (i + 1)));
            if (i == 0) begin
                check("rd OE_N", {31'b0, SRAM_OE_N}, 0);
                check("rd WE_N", {31'b0, SRAM_WE_N}, 1);
            end
            tick(ACC + 1);
        end
        if (LOOP) begin
            check("loop busy", {31'b0, busy}, 1);
            play_strobe(16'h1111);
            tick(ACC + 1);
            pulse_stop();
        end else begin
            check("end out_sample cleared", {16'b0, out_sample}, 0);
            check("end busy", {31'b0, busy}, 0);
            strobe(16'h1111);
            tick(ACC + 1);
            check("5th strobe out_sample", {16'b0, out_sample}, 0);
            check("5th strobe overrun", {31'b0, overrun}, 0);
        end
        check("play busy after", {31'b0, busy}, 0);
        check("play read count", rd_cnt - rd0, LOOP ? 5 : 4);

        // Overrun, and stop issued in the middle of a write
        pulse_start(1'b1);
        wr1 = wr_cnt;
        strobe(16'hAAAA);
        strobe(16'hBBBB);
        check("overrun set", {31'b0, overrun}, 1);
        pulse_stop();
        check("stop mid-write busy", {31'b0, busy}, 1);
        tick(2);
        check("stop mid-write idle", {31'b0, busy}, 0);
        check("overrun one write", wr_cnt - wr1, 1);
        check("overrun mem0", {16'b0, mem[0]}, 32'hAAAA);
        check("overrun mem1", {16'b0, mem[1]}, 32'h2222);
        check("overrun sticky", {31'b0, overrun}, 1);

        // Fill the whole SRAM (8 words), then a 9th strobe
        pulse_start(1'b1);
        check("overrun cleared by start", {31'b0, overrun}, 0);
        check("full cleared by start", {31'b0, full}, 0);
        wr1 = wr_cnt;
        for (int i = 0; i < 9; i++) begin
            strobe(16'(16'h5000 + i));
            tick(ACC + 1);
            if (i == 7) begin
                check("full after 8", {31'b0, full}, 1);
                check("idle after full", {31'b0, busy}, 0);
            end
        end
        check("full write count", wr_cnt - wr1, 8);
        check("full mem0", {16'b0, mem[0]}, 32'h5000);
        check("full mem7", {16'b0, mem[7]}, 32'h5007);
        check("9th no overrun", {31'b0, overrun}, 0);

        // Play back the full recording (rec_len = 8)
        rd1 = rd_cnt;
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            play_strobe(16'(16'h5000 + i));
            tick(ACC + 1);
        end
        pulse_stop();
        check("full play reads", rd_cnt - rd1, 8);
        check("full play idle", {31'b0, busy}, 0);

        // Reset asserted during a write
        pulse_start(1'b1);
        strobe(16'h7777);
        check("pre-reset WE_N", {31'b0, SRAM_WE_N}, 0);
        #3;
        AUD_DACLRCK = 1'b0;
        #1;
        check("reset WE_N", {31'b0, SRAM_WE_N}, 1);
        check("reset CE_N", {31'b0, SRAM_CE_N}, 1);
        check("reset busy", {31'b0, busy}, 0);
        check("reset addr", {29'b0, SRAM_ADDR}, 0);
        tick(2);
        AUD_DACLRCK = 1'b1;
        tick();
        rd1 = rd_cnt;
        pulse_start(1'b0);
        check("play after reset ignored", {31'b0, busy}, 0);
        tick(ACC + 2);
        check("no read after reset", rd_cnt - rd1, 0);
        pulse_start(1'b1);
        check("resume record busy", {31'b0, busy}, 1);
        pulse_stop();
        check("resume stop idle", {31'b0, busy}, 0);

        tick(2);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
